// File: rtl/softstart_pkg.sv
// softstart_pkg: shared constants and the sequencer state encoding.
//   RAMP_W_DEF / STEP_DIV_DEF / SETTLE_CYC_DEF : default parameter values
//   CNT_W                                      : width of prescaler and settle counters
//   ss_state_e                                 : 3-bit sequencer state
package softstart_pkg;

    localparam int RAMP_W_DEF     = 8;
    localparam int STEP_DIV_DEF   = 16;
    localparam int SETTLE_CYC_DEF = 32;
    // 8 bits covers the 256-clock maximum of both STEP_DIV and SETTLE_CYC
    localparam int CNT_W          = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RAMP   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_DONE   = 3'd3,
        ST_FAULT  = 3'd4
    } ss_state_e;

endpackage

// File: rtl/ss_prescaler.sv
// ss_prescaler: divide-by-DIV tick generator with synchronous clear.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   clr  : synchronous clear of the count (wins over en)
//   en   : count enable
//   tick : high during the enabled cycle whose edge wraps the count to 0
module ss_prescaler
    import softstart_pkg::*;
#(
    parameter int DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/softstart_seq.sv
// softstart_seq: soft-start reference ramp sequencer.
//   clk, rst            : clock and synchronous active-high reset
//   en                  : level-sensitive soft-start enable
//   fault               : synchronised fault detect
//   ramp_code           : reference DAC code, ramps 0..all-ones
//   ramp_active         : high while ramping or settling
//   nofault_done        : soft-start finished cleanly (DFT probe source)
//   fault_latched       : high while a fault is held
//   CELG, CELSUB, CELV  : supply pins, no logic function
module softstart_seq
    import softstart_pkg::*;
#(
    parameter int RAMP_W     = RAMP_W_DEF,
    parameter int STEP_DIV   = STEP_DIV_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              fault,
    output logic [RAMP_W-1:0] ramp_code,
    output logic              ramp_active,
    output logic              nofault_done,
    output logic              fault_latched,
    input  logic              CELG,
    input  logic              CELSUB,
    input  logic              CELV
);

    localparam logic [RAMP_W-1:0] CODE_MAX    = '1;
    localparam logic [RAMP_W-1:0] CODE_PENULT = CODE_MAX - RAMP_W'(1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

    ss_state_e         state_q, state_d;
    logic [RAMP_W-1:0] code_q, code_d;
    logic [CNT_W-1:0]  settle_q, settle_d;
    logic              presc_en, presc_clr, step_tick;

    logic unused_supply;
    assign unused_supply = CELG ^ CELSUB ^ CELV;

    // Prescaler runs only in RAMP and is cleared on any edge that leaves RAMP,
    // so every ramp restarts with a full step period.
    assign presc_en  = (state_q == ST_RAMP);
    assign presc_clr = (state_d != ST_RAMP);

    ss_prescaler #(.DIV(STEP_DIV)) u_presc (
        .clk  (clk),
        .rst  (rst),
        .clr  (presc_clr),
        .en   (presc_en),
        .tick (step_tick)
    );

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        settle_d = '0;
        unique case (state_q)
            ST_IDLE: begin
                code_d = '0;
                if (en) state_d = ST_RAMP;
            end
            ST_RAMP: begin
                if (fault) begin
                    state_d = ST_FAULT;
                    code_d  = '0;
                end else if (!en) begin
                    state_d = ST_IDLE;
                    code_d  = '0;
                end else if (step_tick) begin
                    code_d = code_q + RAMP_W'(1);
                    // leave on the step that lands on all-ones: no wrap
                    if (code_q == CODE_PENULT) state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (fault) begin
                    state_d = ST_FAULT;
                    code_d  = '0;
                end else if (!en) begin
                    state_d = ST_IDLE;
                    code_d  = '0;
                end else if (settle_q == SETTLE_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    settle_d = settle_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (fault) begin
                    state_d = ST_FAULT;
                    code_d  = '0;
                end else if (!en) begin
                    state_d = ST_IDLE;
                    code_d  = '0;
                end
            end
            ST_FAULT: begin
                code_d = '0;
                // fault is sticky until en drops, whatever fault does
                if (!en) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                code_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            code_q   <= '0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            settle_q <= settle_d;
        end
    end

    assign ramp_code     = code_q;
    assign ramp_active   = (state_q == ST_RAMP) || (state_q == ST_SETTLE);
    assign nofault_done  = (state_q == ST_DONE);
    assign fault_latched = (state_q == ST_FAULT);

endmodule

// File: tb/tb_softstart_seq.sv
// Bench: two instances share stimulus -- A (RAMP_W=4, STEP_DIV=2, SETTLE_CYC=3)
// and B (RAMP_W=4, STEP_DIV=1, SETTLE_CYC=1). A time-based model predicts both
// every cycle; literal checks pin the key latencies.
module tb_softstart_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic fault = 1'b0;
    logic [3:0] code_a, code_b;
    logic act_a, act_b, done_a, done_b, flt_a, flt_b;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    softstart_seq #(.RAMP_W(4), .STEP_DIV(2), .SETTLE_CYC(3)) dut_a (
        .clk(clk), .rst(rst), .en(en), .fault(fault),
        .ramp_code(code_a), .ramp_active(act_a), .nofault_done(done_a),
        .fault_latched(flt_a), .CELG(1'b1), .CELSUB(1'b0), .CELV(1'b1)
    );

    softstart_seq #(.RAMP_W(4), .STEP_DIV(1), .SETTLE_CYC(1)) dut_b (
        .clk(clk), .rst(rst), .en(en), .fault(fault),
        .ramp_code(code_b), .ramp_active(act_b), .nofault_done(done_b),
        .fault_latched(flt_b), .CELG(1'b1), .CELSUB(1'b0), .CELV(1'b1)
    );

    // Model: mode plus edges elapsed since the ramp began.
    localparam int M_IDLE = 0, M_ACT = 1, M_FLT = 2;
    localparam int STEPS = 15;
    int sd[2] = '{2, 1};
    int sc[2] = '{3, 1};
    int mode[2] = '{M_IDLE, M_IDLE};
    int t[2] = '{0, 0};

    function automatic int done_t(int i);
        return STEPS * sd[i] + sc[i];
    endfunction

    function automatic int m_code(int i);
        if (mode[i] != M_ACT) return 0;
        if (t[i] < STEPS * sd[i]) return t[i] / sd[i];
        return STEPS;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                mode[i] <= M_IDLE;
                t[i]    <= 0;
            end else begin
                case (mode[i])
                    M_IDLE: if (en) begin mode[i] <= M_ACT; t[i] <= 0; end
                    M_ACT: begin
                        if (fault)                mode[i] <= M_FLT;
                        else if (!en)             mode[i] <= M_IDLE;
                        else if (t[i] < done_t(i)) t[i] <= t[i] + 1;
                    end
                    default: if (!en) mode[i] <= M_IDLE;
                endcase
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("a_code",   int'(code_a), m_code(0));
            chk("a_active", int'(act_a),  int'(mode[0] == M_ACT && t[0] < done_t(0)));
            chk("a_done",   int'(done_a), int'(mode[0] == M_ACT && t[0] >= done_t(0)));
            chk("a_fault",  int'(flt_a),  int'(mode[0] == M_FLT));
            chk("b_code",   int'(code_b), m_code(1));
            chk("b_active", int'(act_b),  int'(mode[1] == M_ACT && t[1] < done_t(1)));
            chk("b_done",   int'(done_b), int'(mode[1] == M_ACT && t[1] >= done_t(1)));
            chk("b_fault",  int'(flt_b),  int'(mode[1] == M_FLT));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // reset state
        tick();
        chk_on = 1'b1;
        tick();
        chk("rst_code", int'(code_a), 0);
        chk("rst_flags", int'({act_a, done_a, flt_a}), 0);
        rst = 1'b0;
        run(2);
        // fault ignored in IDLE
        fault = 1'b1;
        tick();
        chk("idle_fault_ignored", int'(flt_a), 0);
        fault = 1'b0;
        tick();

        // nominal ramp
        en = 1'b1;
        tick();                                   // edge 0
        chk("nom_active_e0", int'(act_a), 1);
        for (int k = 1; k <= 33; k++) begin
            tick();
            if (k == 5)  chk("b_code_e5", int'(code_b), 5);
            if (k == 14) chk("nom_code_e14", int'(code_a), 7);
            if (k == 15) chk("b_done_e15", int'(done_b), 0);
            if (k == 16) chk("b_done_e16", int'(done_b), 1);
            if (k == 30) chk("nom_code_e30", int'(code_a), 15);
            if (k == 32) chk("nom_done_e32", int'(done_a), 0);
            if (k == 33) chk("nom_done_e33", int'(done_a), 1);
        end
        run(3);
        chk("nom_code_hold", int'(code_a), 15);
        en = 1'b0;
        tick();
        chk("nom_en_off", int'({act_a, done_a, code_a}), 0);

        // mid-ramp fault
        en = 1'b1;
        tick();
        run(14);
        chk("mf_code7", int'(code_a), 7);
        fault = 1'b1;
        tick();
        chk("mf_latched", int'(flt_a), 1);
        chk("mf_code0", int'(code_a), 0);
        fault = 1'b0;
        run(3);
        chk("mf_hold", int'({flt_a, code_a}), 16);
        en = 1'b0;
        tick();
        chk("mf_exit", int'(flt_a), 0);

        // fault in DONE
        en = 1'b1;
        tick();
        run(34);
        chk("fd_done", int'(done_a), 1);
        fault = 1'b1;
        tick();
        chk("fd_flags", int'({done_a, flt_a, code_a}), 16);
        fault = 1'b0;
        en = 1'b0;
        tick();
        chk("fd_exit", int'(flt_a), 0);

        // fault and en=0 together in SETTLE
        en = 1'b1;
        tick();
        run(31);
        chk("sim_settle", int'({act_a, code_a}), 31);
        fault = 1'b1;
        en = 1'b0;
        tick();
        chk("sim_fault", int'(flt_a), 1);
        fault = 1'b0;
        tick();
        chk("sim_idle", int'({act_a, done_a, flt_a, code_a}), 0);

        // reset mid-ramp
        en = 1'b1;
        tick();
        run(20);
        chk("rm_code10", int'(code_a), 10);
        rst = 1'b1;
        tick();
        chk("rm_rst", int'({act_a, done_a, flt_a, code_a}), 0);
        rst = 1'b0;
        tick();                                   // new edge 0
        chk("rm_restart", int'({act_a, code_a}), 16);
        for (int k = 1; k <= 33; k++) begin
            tick();
            if (k == 32) chk("rm_done_e32", int'(done_a), 0);
            if (k == 33) chk("rm_done_e33", int'(done_a), 1);
        end
        en = 1'b0;
        run(2);

        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
